// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of word-only RAM, peripheral and stack memories.
// Loads and sw take 2 cycles, sb/sh 3 (read-modify-write), errors 1; one access at a time, req honoured only while ready.
module load_store_unit #(
    parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] DMEM_SIZE   = 32'h0000_2000,
    parameter logic [31:0] PERIPH_BASE = 32'h0000_2000,
    parameter logic [31:0] PERIPH_SIZE = 32'h0000_1000,
    parameter logic [31:0] STACK_BASE  = 32'h0000_3000,
    parameter logic [31:0] STACK_SIZE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        periph_read,
    output logic        periph_write,
    output logic        stack_read,
    output logic        stack_write,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] periph_rdata,
    input  logic [31:0] stack_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, old_q, rdata_q;
    logic [2:0]  f3_q, region_q;
    logic        err_q;

    logic [2:0]  hit;
    logic        f3_ok, misal, req_err;
    logic [31:0] sel_rdata, load_ext, merged;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        rd_en, wr_en;

    // Offset compare keeps a zero base from producing an always-true bound.
    assign hit[0] = (addr - DMEM_BASE)   < DMEM_SIZE;
    assign hit[1] = (addr - PERIPH_BASE) < PERIPH_SIZE;
    assign hit[2] = (addr - STACK_BASE)  < STACK_SIZE;

    always_comb begin
        f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !we;
            default:                f3_ok = 1'b0;
        endcase
        misal   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_err = !f3_ok || misal || (hit == 3'b000);
    end

    always_comb begin
        sel_rdata = stack_rdata;
        if (region_q[0])      sel_rdata = dmem_rdata;
        else if (region_q[1]) sel_rdata = periph_rdata;

        case (addr_q[1:0])
            2'b00:   byte_v = sel_rdata[7:0];
            2'b01:   byte_v = sel_rdata[15:8];
            2'b10:   byte_v = sel_rdata[23:16];
            default: byte_v = sel_rdata[31:24];
        endcase
        half_v = addr_q[1] ? sel_rdata[31:16] : sel_rdata[15:0];

        case (f3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'd0, byte_v};
            3'b101:  load_ext = {16'd0, half_v};
            default: load_ext = sel_rdata;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rdata     = 32'd0;
        mem_wdata = 32'd0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (req_err)                   state_d = RESP;
                    else if (!we)                  state_d = LOAD;
                    else if (funct3[1:0] == 2'b10) state_d = STORE;
                    else                           state_d = RMW_RD;
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                state_d = RESP;
            end
            STORE: begin
                wr_en     = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_RD: begin
                rd_en   = 1'b1;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                wr_en     = 1'b1;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP: begin
                done    = 1'b1;
                err     = err_q;
                rdata   = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr = (state_q == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};

    // Gating by rst guarantees no memory write lands in a reset cycle.
    assign dmem_read    = rd_en & region_q[0] & ~rst;
    assign periph_read  = rd_en & region_q[1] & ~rst;
    assign stack_read   = rd_en & region_q[2] & ~rst;
    assign dmem_write   = wr_en & region_q[0] & ~rst;
    assign periph_write = wr_en & region_q[1] & ~rst;
    assign stack_write  = wr_en & region_q[2] & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            old_q    <= 32'd0;
            rdata_q  <= 32'd0;
            f3_q     <= 3'd0;
            region_q <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    addr_q   <= addr;
                    wdata_q  <= wdata;
                    f3_q     <= funct3;
                    err_q    <= req_err;
                    region_q <= req_err ? 3'b000 : hit;
                    rdata_q  <= 32'd0;
                end
                LOAD:    rdata_q <= load_ext;
                RMW_RD:  old_q   <= sel_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory behind all three regions.
module tb_load_store_unit;

    logic        clk, rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        ready, done, err;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        dmem_read, dmem_write, periph_read, periph_write, stack_read, stack_write;
    logic [31:0] dmem_rdata, periph_rdata, stack_rdata;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .periph_read(periph_read), .periph_write(periph_write),
        .stack_read(stack_read), .stack_write(stack_write),
        .dmem_rdata(dmem_rdata), .periph_rdata(periph_rdata), .stack_rdata(stack_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:4095];
    always @(posedge clk)
        if (dmem_write | periph_write | stack_write) mem[mem_addr[13:2]] <= mem_wdata;

    assign dmem_rdata   = dmem_read   ? mem[mem_addr[13:2]] : 32'h5A5A_5A5A;
    assign periph_rdata = periph_read ? mem[mem_addr[13:2]] : 32'hA5A5_A5A5;
    assign stack_rdata  = stack_read  ? mem[mem_addr[13:2]] : 32'h3C3C_3C3C;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_chk = 0, n_pass = 0;
    int rd_cnt = 0, wr_cnt = 0, strobe_cnt = 0, done_cnt = 0, viol = 0;
    logic [31:0] last_wr_addr, last_wr_data, last_rd_addr;
    logic [2:0]  last_wr_region, last_rd_region;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance to the next falling edge, then record strobes and score any done pulse.
    task automatic step();
        int rd_n, wr_n;
        exp_t e;
        @(negedge clk);
        rd_n = int'(dmem_read) + int'(periph_read) + int'(stack_read);
        wr_n = int'(dmem_write) + int'(periph_write) + int'(stack_write);
        if (rd_n + wr_n > 1) viol++;
        if (rd_n + wr_n > 0) strobe_cnt++;
        if (rd_n > 0) begin
            rd_cnt++;
            last_rd_addr   = mem_addr;
            last_rd_region = {stack_read, periph_read, dmem_read};
        end
        if (wr_n > 0) begin
            wr_cnt++;
            last_wr_addr   = mem_addr;
            last_wr_data   = mem_wdata;
            last_wr_region = {stack_write, periph_write, dmem_write};
        end
        if (done && !rst) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("done_without_req", {31'd0, done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("rdata", rdata, e.rdata);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 20) begin
            step();
            g++;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd, input int lat);
        int g;
        g = 0;
        while (!ready && g < 20) begin
            step();
            g++;
        end
        chk("ready_before_req", {31'd0, ready}, 32'd1);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        sb_q.push_back('{e_err, e_rd, cyc + lat});
        step();
        req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        drain();
        step();
    endtask

    typedef struct { logic [31:0] a; logic [31:0] d; logic [2:0] region; } st_t;
    typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] exp; } ld_t;
    typedef struct { logic w; logic [2:0] f3; logic [31:0] a; } er_t;

    st_t stores[7] = '{
        '{32'h0000_2004, 32'hDEAD_BEEF, 3'b010},
        '{32'h0000_3008, 32'h1122_3344, 3'b100},
        '{32'h0000_0010, 32'h80FF_7F01, 3'b001},
        '{32'h0000_1FFC, 32'hA5A5_0001, 3'b001},
        '{32'h0000_2000, 32'h0BAD_CAFE, 3'b010},
        '{32'h0000_3FFC, 32'h7766_5544, 3'b100},
        '{32'h0000_0004, 32'hCAFE_F00D, 3'b001}
    };
    ld_t loads[12] = '{
        '{3'b010, 32'h0000_2004, 32'hDEAD_BEEF},
        '{3'b010, 32'h0000_1FFC, 32'hA5A5_0001},
        '{3'b010, 32'h0000_2000, 32'h0BAD_CAFE},
        '{3'b010, 32'h0000_3FFC, 32'h7766_5544},
        '{3'b000, 32'h0000_0011, 32'h0000_007F},
        '{3'b000, 32'h0000_0012, 32'hFFFF_FFFF},
        '{3'b100, 32'h0000_0012, 32'h0000_00FF},
        '{3'b001, 32'h0000_0012, 32'hFFFF_80FF},
        '{3'b101, 32'h0000_0010, 32'h0000_7F01},
        '{3'b000, 32'h0000_0013, 32'hFFFF_FF80},
        '{3'b101, 32'h0000_0012, 32'h0000_80FF},
        '{3'b100, 32'h0000_0010, 32'h0000_0001}
    };
    er_t errs[6] = '{
        '{1'b0, 3'b010, 32'h0000_2002},
        '{1'b1, 3'b001, 32'h0000_0001},
        '{1'b0, 3'b010, 32'h0000_4000},
        '{1'b0, 3'b011, 32'h0000_0010},
        '{1'b1, 3'b010, 32'h0000_4000},
        '{1'b1, 3'b100, 32'h0000_0010}
    };

    initial begin
        int r0, w0, s0, d0, c;
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_strobes", {26'd0, dmem_read, dmem_write, periph_read, periph_write, stack_read, stack_write}, 32'd0);
        rst = 1'b0;
        step();

        foreach (stores[i]) begin
            w0 = wr_cnt;
            access(1'b1, 3'b010, stores[i].a, stores[i].d, 1'b0, 32'd0, 2);
            chk("sw_write_cycles", wr_cnt - w0, 32'd1);
            chk("sw_region", {29'd0, last_wr_region}, {29'd0, stores[i].region});
            chk("sw_mem_addr", last_wr_addr, stores[i].a);
            chk("sw_mem_wdata", last_wr_data, stores[i].d);
        end

        foreach (loads[i]) begin
            r0 = rd_cnt;
            access(1'b0, loads[i].f3, loads[i].a, 32'd0, 1'b0, loads[i].exp, 2);
            chk("ld_read_cycles", rd_cnt - r0, 32'd1);
            chk("ld_mem_addr", last_rd_addr, {loads[i].a[31:2], 2'b00});
        end

        r0 = rd_cnt; w0 = wr_cnt;
        access(1'b1, 3'b000, 32'h0000_300A, 32'h0000_00AB, 1'b0, 32'd0, 3);
        chk("sb_read_cycles", rd_cnt - r0, 32'd1);
        chk("sb_write_cycles", wr_cnt - w0, 32'd1);
        chk("sb_rd_region", {29'd0, last_rd_region}, 32'd4);
        chk("sb_wr_region", {29'd0, last_wr_region}, 32'd4);
        chk("sb_mem_addr", last_wr_addr, 32'h0000_3008);
        chk("sb_mem_wdata", last_wr_data, 32'h11AB_3344);
        access(1'b0, 3'b010, 32'h0000_3008, 32'd0, 1'b0, 32'h11AB_3344, 2);

        access(1'b1, 3'b001, 32'h0000_0012, 32'hFFFF_1234, 1'b0, 32'd0, 3);
        chk("sh_mem_wdata", last_wr_data, 32'h1234_7F01);
        access(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b0, 32'h1234_7F01, 2);

        foreach (errs[i]) begin
            s0 = strobe_cnt;
            access(errs[i].w, errs[i].f3, errs[i].a, 32'hFFFF_FFFF, 1'b1, 32'd0, 1);
            chk("err_no_strobe", strobe_cnt - s0, 32'd0);
        end

        // Reset lands while the sb is in its write cycle; the access must vanish.
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h0000_0004; wdata = 32'h0000_0055;
        step();
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        step();
        chk("rmw_wr_reached", {31'd0, dmem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_no_dmem_write", {31'd0, dmem_write}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        step();
        step();
        access(1'b0, 3'b010, 32'h0000_0004, 32'd0, 1'b0, 32'hCAFE_F00D, 2);

        // req held across two accesses: second acceptance only in the idle cycle after RESP.
        w0 = wr_cnt; d0 = done_cnt; c = cyc;
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100; wdata = 32'h1357_9BDF;
        sb_q.push_back('{1'b0, 32'd0, c + 2});
        sb_q.push_back('{1'b0, 32'd0, c + 5});
        for (int k = 0; k < 4; k++) step();
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        drain();
        for (int k = 0; k < 3; k++) step();
        chk("held_req_writes", wr_cnt - w0, 32'd2);
        chk("held_req_dones", done_cnt - d0, 32'd2);
        access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b0, 32'h1357_9BDF, 2);

        chk("strobe_rules", viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
